// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its boot loader.
package data_mem_responder_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned DEFAULT_DEPTH_BITS = 10;

endpackage

// File: rtl/data_mem_responder_byte_packer.sv
// Packs the little-endian loader byte stream into 32-bit words; word_valid pulses on
// the 4th byte of a word or on the final byte of the image.
module data_mem_responder_byte_packer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        take,
  input  logic [7:0]  byte_in,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]       byte_cnt;
  logic [3:0][7:0]  lanes;

  assign word_valid = take && (byte_cnt == 2'(BYTES_PER_WORD - 1) || last);

  // Lanes below byte_cnt come from the accumulator, the current byte fills lane
  // byte_cnt, and everything above is zero so a short final word is zero-padded.
  for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
    assign word[8*k +: 8] = (2'(k) < byte_cnt)  ? lanes[k] :
                            (2'(k) == byte_cnt) ? byte_in  : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (take) begin
      if (word_valid) begin
        byte_cnt <= '0;
      end else begin
        byte_cnt        <= byte_cnt + 2'd1;
        lanes[byte_cnt] <= byte_in;
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM for the core's MEM stage, preceded by a boot phase that fills
// RAM from a byte stream while holding the core in reset.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned DEPTH_BITS    = DEFAULT_DEPTH_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [31:0]              data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] data_i,
  output logic [WORD_BITWIDTH-1:0] data_o,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [7:0]               ld_byte_i,
  input  logic                     ld_last_i,
  output logic                     core_rst_o,
  output logic                     err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  state_e                  state, state_next;
  logic [DEPTH_BITS:0]     ptr;
  logic                    err;
  logic [WORD_BITWIDTH-1:0] mem [DEPTH];

  logic                    loading, take, overflow;
  logic [31:0]             packed_word;
  logic                    word_valid;
  logic [DEPTH_BITS-1:0]   idx;
  logic                    out_of_range, misaligned;
  logic                    run_store, run_load, access_err;

  assign loading  = (state == ST_LOAD);
  assign take     = loading && ld_valid_i;
  // ptr reaching DEPTH sets its top bit; it saturates there so later bytes are dropped.
  assign overflow = ptr[DEPTH_BITS];

  data_mem_responder_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .take       (take),
    .byte_in    (ld_byte_i),
    .last       (ld_last_i),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  assign idx          = data_addr_i[DEPTH_BITS+1:2];
  assign out_of_range = |data_addr_i[31:DEPTH_BITS+2];
  assign misaligned   = |data_addr_i[1:0];

  assign run_store  = !loading && data_we_i && !out_of_range;
  assign run_load   = !loading && data_ce_i && !data_we_i && !out_of_range;
  assign access_err = !loading &&
                      (((data_ce_i || data_we_i) && (out_of_range || misaligned)) ||
                       (data_ce_i && data_we_i));

  always_comb begin
    state_next = state;
    if (take && ld_last_i) state_next = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      ptr   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (word_valid && !overflow) ptr <= ptr + (DEPTH_BITS+1)'(1);
      if ((take && overflow) || access_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (word_valid && !overflow) mem[ptr[DEPTH_BITS-1:0]] <= packed_word;
    else if (run_store)          mem[idx] <= data_i;
  end

  always_comb begin
    data_o = '0;
    if (run_load) data_o = mem[idx];
  end

  assign core_rst_o = loading;
  assign ld_ready_o = loading;
  assign err_o      = err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed boot/load sequences, a vector table for RUN corner
// cases, randomized RUN traffic against an array model, and a 4-word overflow instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default depth
  logic        a_rst_n, a_ce, a_we, a_valid, a_ready, a_last, a_core_rst, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_byte;
  // instance B: 4-word depth
  logic        b_rst_n, b_ce, b_we, b_valid, b_ready, b_last, b_core_rst, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_byte;

  data_mem_responder u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .data_ce_i(a_ce), .data_we_i(a_we),
    .data_addr_i(a_addr), .data_i(a_wdata), .data_o(a_rdata),
    .ld_valid_i(a_valid), .ld_ready_o(a_ready), .ld_byte_i(a_byte), .ld_last_i(a_last),
    .core_rst_o(a_core_rst), .err_o(a_err)
  );

  data_mem_responder #(.DEPTH_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .data_ce_i(b_ce), .data_we_i(b_we),
    .data_addr_i(b_addr), .data_i(b_wdata), .data_o(b_rdata),
    .ld_valid_i(b_valid), .ld_ready_o(b_ready), .ld_byte_i(b_byte), .ld_last_i(b_last),
    .core_rst_o(b_core_rst), .err_o(b_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model of instance A's RAM: image byte n lands in word n/4, lane n%4
  logic [31:0] ma [1024];
  bit          ka [1024];
  int          a_n;
  logic [31:0] a_acc;

  typedef struct {
    bit          ce;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    a_ce = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    a_valid = 1'b0; a_byte = '0; a_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1;
    a_n = 0;
    a_acc = '0;
  endtask

  task automatic send_a(input logic [7:0] b, input bit last);
    int lane;
    a_valid = 1'b1; a_byte = b; a_last = last;
    @(posedge clk);
    #1 a_valid = 1'b0; a_last = 1'b0;
    lane = a_n % 4;
    a_acc = a_acc | (32'(b) << (8 * lane));
    if (lane == 3 || last) begin
      if (a_n / 4 < 1024) begin
        ma[a_n / 4] = a_acc;
        ka[a_n / 4] = 1'b1;
      end
      a_acc = '0;
    end
    a_n++;
  endtask

  // drives one core access, returns data_o sampled before the edge, then clocks it
  task automatic run_a(input bit ce, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
    a_ce = ce; a_we = we; a_addr = addr; a_wdata = wdata;
    #1 rdata = a_rdata;
    @(posedge clk);
    #1 a_ce = 1'b0; a_we = 1'b0;
    if (we && addr < 32'h1000) begin
      ma[addr[11:2]] = wdata;
      ka[addr[11:2]] = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  t1 [8];
    logic [31:0] addr;
    int          op;

    b_rst_n = 1'b0; b_ce = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    b_valid = 1'b0; b_byte = '0; b_last = 1'b0;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,   32'hCAFEF00D, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        32'hCAFEF00D, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h10,   32'h1,        32'h0,        1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        32'h1,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,    32'h0,        32'h04030201, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h4,    32'h0,        32'h00000005, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h1000, 32'hBAD0BAD0, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,    32'h0,        32'h04030201, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h2000, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h12,   32'h0,        32'h1,        1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h14,   32'h7,        32'h0,        1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h14,   32'h0,        32'h7,        1'b1};

    // boot image of two full words
    reset_a();
    chk("reset_core_rst", 32'(a_core_rst), 32'd1);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_err", 32'(a_err), 32'd0);
    a_ce = 1'b1; a_addr = '0;
    #1 chk("load_phase_data_o", a_rdata, 32'h0);
    a_ce = 1'b0;
    t1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 8; i++) begin
      send_a(t1[i], i == 7);
      if (i < 7) chk("core_rst_during_load", 32'(a_core_rst), 32'd1);
    end
    chk("core_rst_after_last", 32'(a_core_rst), 32'd0);
    chk("ready_after_last", 32'(a_ready), 32'd0);
    chk("err_after_boot", 32'(a_err), 32'd0);
    run_a(1'b1, 1'b0, 32'h0, '0, rd); chk("boot1_word0", rd, 32'h12345678);
    run_a(1'b1, 1'b0, 32'h4, '0, rd); chk("boot1_word1", rd, 32'hDEADBEEF);

    // short image: partial final word is zero-padded
    reset_a();
    chk("reload_core_rst", 32'(a_core_rst), 32'd1);
    for (int i = 1; i <= 5; i++) send_a(8'(i), i == 5);
    chk("boot2_core_rst", 32'(a_core_rst), 32'd0);
    run_a(1'b1, 1'b0, 32'h0, '0, rd); chk("boot2_word0", rd, 32'h04030201);
    run_a(1'b1, 1'b0, 32'h4, '0, rd); chk("boot2_word1", rd, 32'h00000005);

    // RUN corner cases
    for (int i = 0; i < 12; i++) begin
      run_a(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      chk($sformatf("tbl%0d_data_o", i), rd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].exp_err));
    end

    // randomized RUN traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + ($urandom_range(0, 255) << 2);
      else                           addr = $urandom_range(0, 31) << 2;
      case (op)
        0: begin
          run_a(1'b0, 1'b1, addr, $urandom, rd);
          chk("rand_store_data_o", rd, 32'h0);
        end
        1: begin
          if (addr >= 32'h1000) begin
            run_a(1'b1, 1'b0, addr, '0, rd);
            chk("rand_load_oor", rd, 32'h0);
          end else if (ka[addr[11:2]]) begin
            run_a(1'b1, 1'b0, addr, '0, rd);
            chk("rand_load", rd, ma[addr[11:2]]);
          end
        end
        2: begin
          run_a(1'b1, 1'b1, addr, $urandom, rd);
          chk("rand_both_data_o", rd, 32'h0);
        end
        default: begin
          run_a(1'b0, 1'b0, addr, '0, rd);
          chk("rand_idle_data_o", rd, 32'h0);
        end
      endcase
      chk("rand_err_sticky", 32'(a_err), 32'd1);
    end

    // reset in the middle of a load, then a full reload
    reset_a();
    chk("err_cleared_by_reset", 32'(a_err), 32'd0);
    for (int i = 0; i < 6; i++) send_a(8'h11 + 8'(i), 1'b0);
    chk("core_rst_midload", 32'(a_core_rst), 32'd1);
    reset_a();
    chk("midload_reset_core_rst", 32'(a_core_rst), 32'd1);
    chk("midload_reset_ready", 32'(a_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_a(8'hA0 + 8'(i), i == 7);
    chk("reload_core_rst_low", 32'(a_core_rst), 32'd0);
    chk("reload_err", 32'(a_err), 32'd0);
    run_a(1'b1, 1'b0, 32'h0, '0, rd); chk("reload_word0", rd, 32'hA3A2A1A0);
    run_a(1'b1, 1'b0, 32'h4, '0, rd); chk("reload_word1", rd, 32'hA7A6A5A4);
    for (int i = 2; i < 32; i++) begin
      if (ka[i]) begin
        run_a(1'b1, 1'b0, 32'(i) << 2, '0, rd);
        chk($sformatf("retained_word%0d", i), rd, ma[i]);
      end
    end

    // 4-word instance: 20-byte image overflows after 16 bytes
    repeat (2) @(posedge clk);
    #1 b_rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      b_valid = 1'b1; b_byte = 8'(i); b_last = (i == 20);
      @(posedge clk);
      #1 b_valid = 1'b0; b_last = 1'b0;
      chk($sformatf("ovf_err_byte%0d", i), 32'(b_err), (i >= 17) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_core_rst_byte%0d", i), 32'(b_core_rst), (i < 20) ? 32'd1 : 32'd0);
    end
    for (int w = 0; w < 5; w++) begin
      b_ce = 1'b1; b_addr = 32'(w) << 2;
      #1 chk($sformatf("ovf_word%0d", w), b_rdata,
             (w < 4) ? {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)} : 32'h0);
      @(posedge clk);
      #1 b_ce = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
